mosby_regfile: RTL and testbench

Parametrised architectural register file for the MOSby core, successor to the fixed five-register block (A, X, Y, SP, P). It holds NREGS general-purpose registers of WIDTH bits with two combinational read ports and one write port, plus a register-to-register transfer path. It also contains a stack pointer with push/pull/load and wrap detection, and an 8-bit status register with per-bit write mask and automatic N/Z update. It sits between the decoder/ALU and the bus interface, on the single core clock.

---
 rtl/mosby_pkg.sv | 50 +++++
 rtl/mosby_regfile_if.sv | 61 ++++++
 rtl/mosby_stack_ptr.sv | 68 ++++++
 rtl/mosby_regfile.sv | 113 +++++++++++
 tb/tb_mosby_regfile.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mosby_pkg.sv
// -----------------------------------------------------------------------------
// mosby_pkg
// Shared definitions for the MOSby register file:
//   - status register bit positions (N V U B D I Z C)
//   - stack pointer operation encodings
//   - default reset values for SP, stack page and status
//   - status_merge(): applies a per-bit write mask and pins the fixed bit
// -----------------------------------------------------------------------------
package mosby_pkg;

    // Status register bit positions
    localparam int ST_N = 7;
    localparam int ST_V = 6;
    localparam int ST_U = 5;    // unused bit, always reads 1
    localparam int ST_B = 4;
    localparam int ST_D = 3;
    localparam int ST_I = 2;
    localparam int ST_Z = 1;
    localparam int ST_C = 0;

    // Width of the stack page prefix placed above SP on stack_addr
    localparam int PAGE_W = 8;

    // Default reset values
    localparam logic [7:0]        DEF_SP_RESET   = 8'hFD;
    localparam logic [PAGE_W-1:0] DEF_STACK_PAGE = 8'h01;
    localparam logic [7:0]        DEF_ST_RESET   = 8'h24;

    // Stack pointer operations
    typedef enum logic [1:0] {
        SP_HOLD = 2'b00,
        SP_PUSH = 2'b01,
        SP_PULL = 2'b10,
        SP_LOAD = 2'b11
    } sp_op_e;

    // Bits selected by mask take the new value; the unused bit is forced high
    // so it can never be cleared by any write path.
    function automatic logic [7:0] status_merge(
        input logic [7:0] cur,
        input logic [7:0] mask,
        input logic [7:0] data
    );
        logic [7:0] res;
        res       = (cur & ~mask) | (data & mask);
        res[ST_U] = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/mosby_regfile_if.sv
// -----------------------------------------------------------------------------
// mosby_regfile_if
// Bus bundle between the decoder/ALU (master) and the register file (slave).
//   GP write     : wr_en, wr_sel, wr_data
//   Transfer     : mov_en, mov_src, mov_dst
//   Flag update  : nz_upd
//   Reads        : rd_sel_a, rd_sel_b -> rd_data_a, rd_data_b
//   Stack        : sp_op -> sp_out, stack_addr, sp_wrap
//   Status       : st_mask, st_data -> status
// -----------------------------------------------------------------------------
interface mosby_regfile_if
    import mosby_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
);

    logic                      wr_en;
    logic [SEL_W-1:0]          wr_sel;
    logic [WIDTH-1:0]          wr_data;
    logic                      mov_en;
    logic [SEL_W-1:0]          mov_src;
    logic [SEL_W-1:0]          mov_dst;
    logic                      nz_upd;
    logic [SEL_W-1:0]          rd_sel_a;
    logic [SEL_W-1:0]          rd_sel_b;
    logic [WIDTH-1:0]          rd_data_a;
    logic [WIDTH-1:0]          rd_data_b;
    sp_op_e                    sp_op;
    logic [WIDTH-1:0]          sp_out;
    logic [PAGE_W+WIDTH-1:0]   stack_addr;
    logic                      sp_wrap;
    logic [7:0]                st_mask;
    logic [7:0]                st_data;
    logic [7:0]                status;

    modport master (
        output wr_en, wr_sel, wr_data,
        output mov_en, mov_src, mov_dst,
        output nz_upd,
        output rd_sel_a, rd_sel_b,
        output sp_op,
        output st_mask, st_data,
        input  rd_data_a, rd_data_b,
        input  sp_out, stack_addr, sp_wrap,
        input  status
    );

    modport slave (
        input  wr_en, wr_sel, wr_data,
        input  mov_en, mov_src, mov_dst,
        input  nz_upd,
        input  rd_sel_a, rd_sel_b,
        input  sp_op,
        input  st_mask, st_data,
        output rd_data_a, rd_data_b,
        output sp_out, stack_addr, sp_wrap,
        output status
    );

endinterface

// File: rtl/mosby_stack_ptr.sv
// -----------------------------------------------------------------------------
// mosby_stack_ptr
// Stack pointer with push (decrement), pull (increment) and load.
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   i_sp_op         hold / push / pull / load
//   i_ld_data       value loaded into SP on SP_LOAD
//   o_sp            current SP
//   o_stack_addr    {STACK_PAGE, SP} on push/hold/load, {STACK_PAGE, SP+1} on pull
//   o_sp_wrap       one-cycle pulse after a push from 0 or a pull from all ones
// -----------------------------------------------------------------------------
module mosby_stack_ptr
    import mosby_pkg::*;
#(
    parameter int                WIDTH      = 8,
    parameter logic [WIDTH-1:0]  SP_RESET   = DEF_SP_RESET,
    parameter logic [PAGE_W-1:0] STACK_PAGE = DEF_STACK_PAGE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  sp_op_e                  i_sp_op,
    input  logic [WIDTH-1:0]        i_ld_data,
    output logic [WIDTH-1:0]        o_sp,
    output logic [PAGE_W+WIDTH-1:0] o_stack_addr,
    output logic                    o_sp_wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_sp;
    logic             r_wrap;
    logic [WIDTH-1:0] w_sp_inc;
    logic [WIDTH-1:0] w_sp_dec;

    assign w_sp_inc = r_sp + ONE;
    assign w_sp_dec = r_sp - ONE;

    // The stack is empty-descending: a push writes at SP then decrements,
    // a pull pre-increments, so the pull address is SP+1 in the same cycle.
    assign o_stack_addr = {STACK_PAGE, (i_sp_op == SP_PULL) ? w_sp_inc : r_sp};
    assign o_sp         = r_sp;
    assign o_sp_wrap    = r_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp   <= SP_RESET;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (i_sp_op)
                SP_PUSH: begin
                    r_sp   <= w_sp_dec;
                    r_wrap <= (r_sp == '0);
                end
                SP_PULL: begin
                    r_sp   <= w_sp_inc;
                    r_wrap <= (r_sp == '1);
                end
                SP_LOAD: begin
                    r_sp   <= i_ld_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/mosby_regfile.sv
// -----------------------------------------------------------------------------
// mosby_regfile
// Architectural register file of the MOSby core.
//   - NREGS general-purpose registers (0=A, 1=X, 2=Y), two combinational
//     read ports, one write port and a register-to-register transfer path
//   - stack pointer (mosby_stack_ptr) with push/pull/load and wrap pulse
//   - 8-bit status register with per-bit mask and automatic N/Z update
// Ports:
//   clk, rst   core clock, synchronous active-high reset
//   bus        mosby_regfile_if.slave carrying all data/control signals
// -----------------------------------------------------------------------------
module mosby_regfile
    import mosby_pkg::*;
#(
    parameter int                WIDTH      = 8,
    parameter int                NREGS      = 3,
    parameter int                SEL_W      = 2,
    parameter logic [WIDTH-1:0]  SP_RESET   = DEF_SP_RESET,
    parameter logic [PAGE_W-1:0] STACK_PAGE = DEF_STACK_PAGE,
    parameter logic [7:0]        ST_RESET   = DEF_ST_RESET
) (
    input  logic            clk,
    input  logic            rst,
    mosby_regfile_if.slave  bus
);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [7:0]       r_status;

    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic [WIDTH-1:0] w_mov_val;
    logic             w_wr_hit;
    logic             w_mov_hit;
    logic [WIDTH-1:0] w_nz_val;
    logic [7:0]       w_st_next;

    // Read muxes: a select with no matching register falls through to 0,
    // which also gives an out-of-range mov source the value 0.
    always_comb begin
        w_rd_a    = '0;
        w_rd_b    = '0;
        w_mov_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.rd_sel_a == i[SEL_W-1:0]) w_rd_a    = r_regs[i];
            if (bus.rd_sel_b == i[SEL_W-1:0]) w_rd_b    = r_regs[i];
            if (bus.mov_src  == i[SEL_W-1:0]) w_mov_val = r_regs[i];
        end
    end

    assign bus.rd_data_a = w_rd_a;
    assign bus.rd_data_b = w_rd_b;

    // A write only "happens" when its destination exists
    assign w_wr_hit  = bus.wr_en  && (int'(bus.wr_sel)  < NREGS);
    assign w_mov_hit = bus.mov_en && (int'(bus.mov_dst) < NREGS);

    // GP bank: the explicit write port has priority over the transfer
    // when both target the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (bus.wr_en && bus.wr_sel == i[SEL_W-1:0]) begin
                    r_regs[i] <= bus.wr_data;
                end else if (bus.mov_en && bus.mov_dst == i[SEL_W-1:0]) begin
                    r_regs[i] <= w_mov_val;
                end
            end
        end
    end

    // Status next value: N/Z follow the value that actually lands in the
    // bank (write port wins over transfer); explicit mask bits then
    // override whatever N/Z produced.
    always_comb begin
        w_nz_val  = w_wr_hit ? bus.wr_data : w_mov_val;
        w_st_next = r_status;
        if (bus.nz_upd && (w_wr_hit || w_mov_hit)) begin
            w_st_next[ST_N] = w_nz_val[WIDTH-1];
            w_st_next[ST_Z] = (w_nz_val == '0);
        end
        w_st_next = status_merge(w_st_next, bus.st_mask, bus.st_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= status_merge(ST_RESET, 8'h00, 8'h00);
        end else begin
            r_status <= w_st_next;
        end
    end

    assign bus.status = r_status;

    mosby_stack_ptr #(
        .WIDTH      (WIDTH),
        .SP_RESET   (SP_RESET),
        .STACK_PAGE (STACK_PAGE)
    ) u_stack_ptr (
        .clk          (clk),
        .rst          (rst),
        .i_sp_op      (bus.sp_op),
        .i_ld_data    (bus.wr_data),
        .o_sp         (bus.sp_out),
        .o_stack_addr (bus.stack_addr),
        .o_sp_wrap    (bus.sp_wrap)
    );

endmodule

// File: tb/tb_mosby_regfile.sv
// -----------------------------------------------------------------------------
// tb_mosby_regfile
// Directed scenarios followed by random traffic, all compared against a
// behavioural model of the register file held in arrays.
// -----------------------------------------------------------------------------
module tb_mosby_regfile;
    import mosby_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mosby_regfile_if #(.WIDTH(8), .SEL_W(2)) bus ();

    mosby_regfile #(
        .WIDTH      (8),
        .NREGS      (3),
        .SEL_W      (2),
        .SP_RESET   (8'hFD),
        .STACK_PAGE (8'h01),
        .ST_RESET   (8'h24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Model state; entry 3 stands for "no such register" and stays 0
    logic [7:0] m_regs [4];
    logic [7:0] m_sp;
    logic [7:0] m_st;
    logic       m_wrap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst          = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_sel   = '0;
        bus.wr_data  = '0;
        bus.mov_en   = 1'b0;
        bus.mov_src  = '0;
        bus.mov_dst  = '0;
        bus.nz_upd   = 1'b0;
        bus.rd_sel_a = '0;
        bus.rd_sel_b = '0;
        bus.sp_op    = SP_HOLD;
        bus.st_mask  = '0;
        bus.st_data  = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_sp   = 8'hFD;
        m_st   = 8'h24;
        m_wrap = 1'b0;
    endtask

    // One clock edge of the architectural behaviour, using the inputs
    // presently driven on the bus.
    task automatic model_edge();
        logic [7:0] src;
        logic [7:0] val;
        logic       wr_ok;
        logic       mv_ok;
        if (rst) begin
            model_reset();
        end else begin
            src   = m_regs[bus.mov_src];
            wr_ok = bus.wr_en  && (bus.wr_sel  != 2'd3);
            mv_ok = bus.mov_en && (bus.mov_dst != 2'd3);
            if (mv_ok) m_regs[bus.mov_dst] = src;
            if (wr_ok) m_regs[bus.wr_sel]  = bus.wr_data;
            val = wr_ok ? bus.wr_data : src;
            if (bus.nz_upd && (wr_ok || mv_ok)) begin
                m_st[7] = val[7];
                m_st[1] = (val == 8'h00);
            end
            for (int i = 0; i < 8; i++) begin
                if (bus.st_mask[i]) m_st[i] = bus.st_data[i];
            end
            m_st[5] = 1'b1;
            m_wrap = 1'b0;
            if (bus.sp_op == SP_PUSH) begin
                m_wrap = (m_sp == 8'h00);
                m_sp   = m_sp - 8'd1;
            end else if (bus.sp_op == SP_PULL) begin
                m_wrap = (m_sp == 8'hFF);
                m_sp   = m_sp + 8'd1;
            end else if (bus.sp_op == SP_LOAD) begin
                m_sp   = bus.wr_data;
            end
        end
    endtask

    function automatic logic [15:0] exp_addr();
        logic [7:0] lo;
        lo = (bus.sp_op == SP_PULL) ? m_sp + 8'd1 : m_sp;
        return {8'h01, lo};
    endfunction

    // Called with inputs already driven (just after a falling edge).
    // Checks combinational outputs, clocks once, checks registered outputs,
    // and returns at the next falling edge.
    task automatic step();
        #1;
        chk("rd_data_a",  bus.rd_data_a,  m_regs[bus.rd_sel_a]);
        chk("rd_data_b",  bus.rd_data_b,  m_regs[bus.rd_sel_b]);
        chk("stack_addr", bus.stack_addr, exp_addr());
        @(posedge clk);
        model_edge();
        #1;
        chk("sp_out",  bus.sp_out,  m_sp);
        chk("status",  bus.status,  m_st);
        chk("sp_wrap", bus.sp_wrap, m_wrap);
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        for (int s = 0; s < 3; s++) begin
            bus.rd_sel_a = 2'(s);
            #1;
            chk("reset_gp", bus.rd_data_a, 8'h00);
        end
        chk("reset_sp",     bus.sp_out,  8'hFD);
        chk("reset_status", bus.status,  8'h24);
        chk("reset_wrap",   bus.sp_wrap, 1'b0);
        bus.rd_sel_a = 2'd3;
        #1;
        chk("oob_read", bus.rd_data_a, 8'h00);
        @(negedge clk);

        // Write with N/Z update: negative then zero
        idle();
        bus.wr_en = 1'b1; bus.wr_sel = 2'd0; bus.wr_data = 8'h80; bus.nz_upd = 1'b1;
        step();
        chk("nz_neg_status", bus.status, 8'hA4);
        idle();
        bus.wr_en = 1'b1; bus.wr_sel = 2'd0; bus.wr_data = 8'h00; bus.nz_upd = 1'b1;
        step();
        chk("nz_zero_status", bus.status, 8'h26);
        chk("nz_zero_a",      bus.rd_data_a, 8'h00);

        // Write beats transfer on the same destination
        idle();
        bus.wr_en = 1'b1; bus.wr_sel = 2'd0; bus.wr_data = 8'h3C;
        step();
        idle();
        bus.wr_en = 1'b1; bus.wr_sel = 2'd1; bus.wr_data = 8'h55;
        bus.mov_en = 1'b1; bus.mov_src = 2'd0; bus.mov_dst = 2'd1;
        step();
        idle();
        bus.rd_sel_a = 2'd1;
        #1;
        chk("wr_beats_mov_x", bus.rd_data_a, 8'h55);
        @(negedge clk);

        // Full status mask: bit 5 survives
        idle();
        bus.st_mask = 8'hFF; bus.st_data = 8'h00;
        step();
        chk("mask_all_zero", bus.status, 8'h20);

        // Stack wrap in both directions
        idle();
        bus.sp_op = SP_LOAD; bus.wr_data = 8'h00;
        step();
        chk("load_no_wrap", bus.sp_wrap, 1'b0);
        idle();
        bus.sp_op = SP_PUSH;
        #1;
        chk("push_addr", bus.stack_addr, 16'h0100);
        step();
        chk("push_sp",   bus.sp_out,  8'hFF);
        chk("push_wrap", bus.sp_wrap, 1'b1);
        idle();
        step();
        chk("push_wrap_gone", bus.sp_wrap, 1'b0);
        idle();
        bus.sp_op = SP_PULL;
        #1;
        chk("pull_addr", bus.stack_addr, 16'h0100);
        step();
        chk("pull_sp",   bus.sp_out,  8'h00);
        chk("pull_wrap", bus.sp_wrap, 1'b1);
        idle();
        step();

        // Reset in the middle of a push burst
        idle();
        rst = 1'b1;
        step();
        idle();
        bus.sp_op = SP_PUSH;
        step();
        bus.sp_op = SP_PUSH;
        rst = 1'b1;
        step();
        idle();
        bus.sp_op = SP_PUSH;
        #1;
        chk("midrst_sp",   bus.sp_out,  8'hFD);
        chk("midrst_wrap", bus.sp_wrap, 1'b0);
        step();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            rst          = ($urandom_range(0, 49) == 0);
            bus.wr_en    = $urandom_range(0, 1) == 1;
            bus.wr_sel   = 2'($urandom_range(0, 3));
            bus.wr_data  = 8'($urandom);
            bus.mov_en   = $urandom_range(0, 1) == 1;
            bus.mov_src  = 2'($urandom_range(0, 3));
            bus.mov_dst  = 2'($urandom_range(0, 3));
            bus.nz_upd   = $urandom_range(0, 1) == 1;
            bus.rd_sel_a = 2'($urandom_range(0, 3));
            bus.rd_sel_b = 2'($urandom_range(0, 3));
            bus.sp_op    = sp_op_e'($urandom_range(0, 3));
            bus.st_mask  = 8'($urandom & $urandom & $urandom);
            bus.st_data  = 8'($urandom);
            // Occasionally steer SP to the wrap boundaries
            if ($urandom_range(0, 9) == 0) begin
                bus.sp_op   = SP_LOAD;
                bus.wr_data = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
